// File: rtl/axilite_arbiter.sv
// Round-robin arbiter that shares one AXI-lite master port between NS requesters.
// Write and read paths each hold one transaction in flight; payload is muxed from the granted slice.
module axilite_arbiter #(
  parameter  int NS               = 2,
  parameter  int C_AXI_ADDR_WIDTH = 32,
  parameter  int C_AXI_DATA_WIDTH = 32,
  localparam int AW               = C_AXI_ADDR_WIDTH,
  localparam int DW               = C_AXI_DATA_WIDTH,
  localparam int SW               = C_AXI_DATA_WIDTH / 8
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  // slave-side write address / data / response
  input  logic [NS-1:0]      S_AXI_AWVALID,
  output logic [NS-1:0]      S_AXI_AWREADY,
  input  logic [NS*AW-1:0]   S_AXI_AWADDR,
  input  logic [NS*3-1:0]    S_AXI_AWPROT,
  input  logic [NS-1:0]      S_AXI_WVALID,
  output logic [NS-1:0]      S_AXI_WREADY,
  input  logic [NS*DW-1:0]   S_AXI_WDATA,
  input  logic [NS*SW-1:0]   S_AXI_WSTRB,
  output logic [NS-1:0]      S_AXI_BVALID,
  input  logic [NS-1:0]      S_AXI_BREADY,
  output logic [NS*2-1:0]    S_AXI_BRESP,
  // slave-side read address / data
  input  logic [NS-1:0]      S_AXI_ARVALID,
  output logic [NS-1:0]      S_AXI_ARREADY,
  input  logic [NS*AW-1:0]   S_AXI_ARADDR,
  input  logic [NS*3-1:0]    S_AXI_ARPROT,
  output logic [NS-1:0]      S_AXI_RVALID,
  input  logic [NS-1:0]      S_AXI_RREADY,
  output logic [NS*DW-1:0]   S_AXI_RDATA,
  output logic [NS*2-1:0]    S_AXI_RRESP,
  // master port
  output logic               M_AXI_AWVALID,
  input  logic               M_AXI_AWREADY,
  output logic [AW-1:0]      M_AXI_AWADDR,
  output logic [2:0]         M_AXI_AWPROT,
  output logic               M_AXI_WVALID,
  input  logic               M_AXI_WREADY,
  output logic [DW-1:0]      M_AXI_WDATA,
  output logic [SW-1:0]      M_AXI_WSTRB,
  input  logic               M_AXI_BVALID,
  output logic               M_AXI_BREADY,
  input  logic [1:0]         M_AXI_BRESP,
  output logic               M_AXI_ARVALID,
  input  logic               M_AXI_ARREADY,
  output logic [AW-1:0]      M_AXI_ARADDR,
  output logic [2:0]         M_AXI_ARPROT,
  input  logic               M_AXI_RVALID,
  output logic               M_AXI_RREADY,
  input  logic [DW-1:0]      M_AXI_RDATA,
  input  logic [1:0]         M_AXI_RRESP
);

  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rst_e;

  // First requester at or after ptr, wrapping modulo NS.
  function automatic logic [IW-1:0] rr_pick(input logic [NS-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic [IW-1:0] ix;
    int            idx;
    pick = ptr;
    for (int k = NS-1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NS) idx = idx - NS;
      ix = IW'(idx);
      if (req[ix]) pick = ix;
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] g);
    return (g == IW'(NS-1)) ? '0 : g + 1'b1;
  endfunction

  // ---------------- write path ----------------
  wst_e          wst_q, wst_d;
  logic [IW-1:0] wgnt_q, wgnt_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wst_q     <= W_IDLE;
      wgnt_q    <= '0;
      wr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      wst_q     <= wst_d;
      wgnt_q    <= wgnt_d;
      wr_ptr_q  <= wr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign M_AXI_AWADDR = S_AXI_AWADDR[int'(wgnt_q)*AW +: AW];
  assign M_AXI_AWPROT = S_AXI_AWPROT[int'(wgnt_q)*3 +: 3];
  assign M_AXI_WDATA  = S_AXI_WDATA[int'(wgnt_q)*DW +: DW];
  assign M_AXI_WSTRB  = S_AXI_WSTRB[int'(wgnt_q)*SW +: SW];
  assign S_AXI_BRESP  = {NS{M_AXI_BRESP}};

  // Readies depend only on M-side ready and local state, never on another slice's VALID.
  always_comb begin
    S_AXI_AWREADY = '0;
    S_AXI_WREADY  = '0;
    S_AXI_BVALID  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    if (wst_q == W_ADDR) begin
      M_AXI_AWVALID         = S_AXI_AWVALID[wgnt_q] & ~aw_done_q;
      M_AXI_WVALID          = S_AXI_WVALID[wgnt_q] & ~w_done_q;
      S_AXI_AWREADY[wgnt_q] = M_AXI_AWREADY & ~aw_done_q;
      S_AXI_WREADY[wgnt_q]  = M_AXI_WREADY & ~w_done_q;
    end
    if (wst_q == W_RESP) begin
      S_AXI_BVALID[wgnt_q] = M_AXI_BVALID;
      M_AXI_BREADY         = S_AXI_BREADY[wgnt_q];
    end
  end

  always_comb begin
    wst_d     = wst_q;
    wgnt_d    = wgnt_q;
    wr_ptr_d  = wr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (wst_q)
      W_IDLE: begin
        if (|S_AXI_AWVALID) begin
          wgnt_d = rr_pick(S_AXI_AWVALID, wr_ptr_q);
          wst_d  = W_ADDR;
        end
      end
      W_ADDR: begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)          wst_d     = W_RESP;
      end
      W_RESP: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          wr_ptr_d  = ptr_next(wgnt_q);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wst_d     = W_IDLE;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // ---------------- read path ----------------
  rst_e          rst_q, rst_d;
  logic [IW-1:0] rgnt_q, rgnt_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_q    <= R_IDLE;
      rgnt_q   <= '0;
      rd_ptr_q <= '0;
    end else begin
      rst_q    <= rst_d;
      rgnt_q   <= rgnt_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign M_AXI_ARADDR = S_AXI_ARADDR[int'(rgnt_q)*AW +: AW];
  assign M_AXI_ARPROT = S_AXI_ARPROT[int'(rgnt_q)*3 +: 3];
  assign S_AXI_RDATA  = {NS{M_AXI_RDATA}};
  assign S_AXI_RRESP  = {NS{M_AXI_RRESP}};

  always_comb begin
    S_AXI_ARREADY = '0;
    S_AXI_RVALID  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    if (rst_q == R_ADDR) begin
      M_AXI_ARVALID         = S_AXI_ARVALID[rgnt_q];
      S_AXI_ARREADY[rgnt_q] = M_AXI_ARREADY;
    end
    if (rst_q == R_DATA) begin
      S_AXI_RVALID[rgnt_q] = M_AXI_RVALID;
      M_AXI_RREADY         = S_AXI_RREADY[rgnt_q];
    end
  end

  always_comb begin
    rst_d    = rst_q;
    rgnt_d   = rgnt_q;
    rd_ptr_d = rd_ptr_q;
    case (rst_q)
      R_IDLE: begin
        if (|S_AXI_ARVALID) begin
          rgnt_d = rr_pick(S_AXI_ARVALID, rd_ptr_q);
          rst_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) rst_d = R_DATA;
      end
      R_DATA: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          rd_ptr_d = ptr_next(rgnt_q);
          rst_d    = R_IDLE;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axilite_arbiter.sv
// Scoreboard bench for axilite_arbiter: stimulus pushes expected M-side and slave-side
// transactions into queues, monitors pop and compare as the DUT presents them.
module tb_axilite_arbiter;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int SI = 1;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [NS-1:0]    S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [NS-1:0]    S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic [NS-1:0]    S_AXI_RVALID, S_AXI_RREADY;
  logic [NS*AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [NS*3-1:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic [NS*DW-1:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [NS*SW-1:0] S_AXI_WSTRB;
  logic [NS*2-1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic             M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic             M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic             M_AXI_RVALID, M_AXI_RREADY;
  logic [AW-1:0]    M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]       M_AXI_AWPROT, M_AXI_ARPROT;
  logic [DW-1:0]    M_AXI_WDATA, M_AXI_RDATA;
  logic [SW-1:0]    M_AXI_WSTRB;
  logic [1:0]       M_AXI_BRESP, M_AXI_RRESP;

  axilite_arbiter #(.NS(NS), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RRESP(S_AXI_RRESP),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } mw_t;
  typedef struct packed { logic [7:0] slv; logic [1:0] resp; } b_t;
  typedef struct packed { logic [7:0] slv; logic [31:0] data; logic [1:0] resp; } r_t;
  mw_t         exp_mw[$];
  b_t          exp_b[$];
  r_t          exp_r[$];
  logic [31:0] exp_mar[$];

  // M-side responder: BRESP = SLVERR when addr[12] set; RDATA = {16'hDEAD, addr[15:0]}.
  int          r_delay = 0;
  logic        have_aw, have_w, rpend;
  logic [31:0] cap_addr, cap_data, rd_addr;
  logic [3:0]  cap_strb;
  int          rcnt;
  mw_t         mw_e;

  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] ar_cap;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_ARREADY = 1'b1;
    M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00; M_AXI_RVALID = 1'b0;
    M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    have_aw = 1'b0; have_w = 1'b0; rpend = 1'b0; rcnt = 0;
    cap_addr = '0; cap_data = '0; cap_strb = '0; rd_addr = '0; ar_cap = '0;
    forever begin
      @(negedge ACLK);
      aw_hs = ARESETN & M_AXI_AWVALID & M_AXI_AWREADY;
      w_hs  = ARESETN & M_AXI_WVALID & M_AXI_WREADY;
      b_hs  = ARESETN & M_AXI_BVALID & M_AXI_BREADY;
      ar_hs = ARESETN & M_AXI_ARVALID & M_AXI_ARREADY;
      r_hs  = ARESETN & M_AXI_RVALID & M_AXI_RREADY;
      if (aw_hs) cap_addr = M_AXI_AWADDR;
      if (w_hs) begin cap_data = M_AXI_WDATA; cap_strb = M_AXI_WSTRB; end
      if (ar_hs) ar_cap = M_AXI_ARADDR;
      @(posedge ACLK); #1;
      if (!ARESETN) begin
        M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
        have_aw = 1'b0; have_w = 1'b0; rpend = 1'b0;
      end else begin
        if (b_hs) M_AXI_BVALID = 1'b0;
        if (r_hs) M_AXI_RVALID = 1'b0;
        if (aw_hs) have_aw = 1'b1;
        if (w_hs)  have_w  = 1'b1;
        if (have_aw && have_w) begin
          if (exp_mw.size() == 0) miss("m_write_unexpected");
          else begin
            mw_e = exp_mw.pop_front();
            chk("m_awaddr", 64'(cap_addr), 64'(mw_e.addr));
            chk("m_wdata",  64'(cap_data), 64'(mw_e.data));
            chk("m_wstrb",  64'(cap_strb), 64'(mw_e.strb));
          end
          M_AXI_BVALID = 1'b1;
          M_AXI_BRESP  = cap_addr[12] ? 2'b10 : 2'b00;
          have_aw = 1'b0; have_w = 1'b0;
        end
        if (ar_hs) begin
          if (exp_mar.size() == 0) miss("m_read_unexpected");
          else chk("m_araddr", 64'(ar_cap), 64'(exp_mar.pop_front()));
          rd_addr = ar_cap; rpend = 1'b1; rcnt = r_delay;
        end
        if (rpend) begin
          if (rcnt == 0) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RDATA  = {16'hDEAD, rd_addr[15:0]};
            M_AXI_RRESP  = rd_addr[12] ? 2'b10 : 2'b00;
            rpend = 1'b0;
          end else rcnt--;
        end
      end
    end
  end

  // Slave-side B and R monitors.
  initial begin
    b_t be;
    r_t re;
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        for (int i = 0; i < NS; i++) begin
          if (S_AXI_BVALID[SI'(i)] && S_AXI_BREADY[SI'(i)]) begin
            if (exp_b.size() == 0) miss("b_unexpected");
            else begin
              be = exp_b.pop_front();
              chk("b_slave", 64'(i), 64'(be.slv));
              chk("b_resp", 64'(S_AXI_BRESP[i*2 +: 2]), 64'(be.resp));
              chk("b_onehot", 64'($countones(S_AXI_BVALID)), 64'(1));
            end
          end
          if (S_AXI_RVALID[SI'(i)] && S_AXI_RREADY[SI'(i)]) begin
            if (exp_r.size() == 0) miss("r_unexpected");
            else begin
              re = exp_r.pop_front();
              chk("r_slave", 64'(i), 64'(re.slv));
              chk("r_data", 64'(S_AXI_RDATA[i*DW +: DW]), 64'(re.data));
              chk("r_resp", 64'(S_AXI_RRESP[i*2 +: 2]), 64'(re.resp));
              chk("r_onehot", 64'($countones(S_AXI_RVALID)), 64'(1));
            end
          end
        end
      end
    end
  end

  task automatic send_aw_w(input int s, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] st, input int lead);
    logic aw_ok, w_ok, aw_hit, w_hit;
    int cyc;
    S_AXI_WDATA[s*DW +: DW] = d;
    S_AXI_WSTRB[s*SW +: SW] = st;
    S_AXI_WVALID[SI'(s)] = 1'b1;
    for (int k = 0; k < lead; k++) begin
      @(negedge ACLK);
      chk("wready_before_grant", 64'(S_AXI_WREADY[SI'(s)]), 64'(0));
      @(posedge ACLK); #1;
    end
    S_AXI_AWADDR[s*AW +: AW] = a;
    S_AXI_AWPROT[s*3 +: 3] = 3'(s);
    S_AXI_AWVALID[SI'(s)] = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 200) begin
      @(negedge ACLK);
      aw_hit = S_AXI_AWVALID[SI'(s)] & S_AXI_AWREADY[SI'(s)];
      w_hit  = S_AXI_WVALID[SI'(s)] & S_AXI_WREADY[SI'(s)];
      @(posedge ACLK); #1;
      if (aw_hit) begin aw_ok = 1'b1; S_AXI_AWVALID[SI'(s)] = 1'b0; end
      if (w_hit)  begin w_ok  = 1'b1; S_AXI_WVALID[SI'(s)]  = 1'b0; end
      cyc++;
    end
    if (!(aw_ok && w_ok)) begin
      miss($sformatf("aw_w_timeout slave %0d", s));
      S_AXI_AWVALID[SI'(s)] = 1'b0;
      S_AXI_WVALID[SI'(s)] = 1'b0;
    end
  endtask

  task automatic get_b(input int s, input int delay);
    logic got;
    int cyc;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge ACLK);
      got = S_AXI_BVALID[SI'(s)];
      cyc++;
    end
    if (!got) begin
      miss($sformatf("b_timeout slave %0d", s));
      return;
    end
    for (int k = 0; k < delay; k++) begin
      chk("bvalid_held", 64'(S_AXI_BVALID[SI'(s)]), 64'(1));
      chk("m_bready_low", 64'(M_AXI_BREADY), 64'(0));
      chk("no_aw_grant_in_resp", 64'({M_AXI_AWVALID, S_AXI_AWREADY}), 64'(0));
      @(negedge ACLK);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY[SI'(s)] = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY[SI'(s)] = 1'b0;
  endtask

  task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int lead, input int bdelay);
    send_aw_w(s, a, d, st, lead);
    get_b(s, bdelay);
  endtask

  task automatic do_read(input int s, input logic [31:0] a);
    logic ok, hit;
    int cyc;
    S_AXI_ARADDR[s*AW +: AW] = a;
    S_AXI_ARPROT[s*3 +: 3] = 3'(s);
    S_AXI_ARVALID[SI'(s)] = 1'b1;
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge ACLK);
      hit = S_AXI_ARREADY[SI'(s)];
      @(posedge ACLK); #1;
      if (hit) begin ok = 1'b1; S_AXI_ARVALID[SI'(s)] = 1'b0; end
      cyc++;
    end
    if (!ok) begin
      miss($sformatf("ar_timeout slave %0d", s));
      S_AXI_ARVALID[SI'(s)] = 1'b0;
      return;
    end
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge ACLK);
      ok = S_AXI_RVALID[SI'(s)];
      cyc++;
    end
    if (!ok) begin
      miss($sformatf("r_timeout slave %0d", s));
      return;
    end
    @(posedge ACLK); #1;
    S_AXI_RREADY[SI'(s)] = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY[SI'(s)] = 1'b0;
  endtask

  function automatic logic [63:0] quiet_vec();
    return 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
                M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
  endfunction

  function automatic mw_t mw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    mw_t e;
    e.addr = a; e.data = d; e.strb = st;
    return e;
  endfunction

  function automatic b_t bx(input int s, input logic [1:0] r);
    b_t e;
    e.slv = 8'(s); e.resp = r;
    return e;
  endfunction

  initial begin
    r_t re;
    S_AXI_AWVALID = '0; S_AXI_WVALID = '0; S_AXI_BREADY = '0;
    S_AXI_ARVALID = '0; S_AXI_RREADY = '0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0;

    // reset state and first cycle after release
    #12;
    chk("reset_quiet", quiet_vec(), 64'(0));
    @(posedge ACLK); #3;
    ARESETN = 1'b1;
    #1;
    chk("post_reset_quiet", quiet_vec(), 64'(0));
    @(posedge ACLK); #1;

    // 1: single write from slave 1
    exp_mw.push_back(mw(32'h0000_0010, 32'h1111_2222, 4'h3));
    exp_b.push_back(bx(1, 2'b00));
    do_write(1, 32'h0000_0010, 32'h1111_2222, 4'h3, 0, 0);

    // 2: both slaves, 4 writes each; grants alternate 0,1,0,1...
    for (int k = 0; k < 4; k++) begin
      exp_mw.push_back(mw(32'h0000_0100 + 32'(k*4), 32'hA000_0000 + 32'(k), 4'hF));
      exp_b.push_back(bx(0, 2'b00));
      exp_mw.push_back(mw(32'h0000_1200 + 32'(k*4), 32'hB000_0000 + 32'(k), 4'h3));
      exp_b.push_back(bx(1, 2'b10));
    end
    fork
      begin
        for (int k = 0; k < 4; k++)
          do_write(0, 32'h0000_0100 + 32'(k*4), 32'hA000_0000 + 32'(k), 4'hF, 0, 0);
      end
      begin
        for (int k = 0; k < 4; k++)
          do_write(1, 32'h0000_1200 + 32'(k*4), 32'hB000_0000 + 32'(k), 4'h3, 0, 0);
      end
    join

    // 3: W leads AW by 3 cycles on slave 0
    exp_mw.push_back(mw(32'h0000_0200, 32'h3333_0003, 4'h5));
    exp_b.push_back(bx(0, 2'b00));
    do_write(0, 32'h0000_0200, 32'h3333_0003, 4'h5, 3, 0);

    // 4: read on slave 1 alongside write on slave 0, R delayed 5 cycles
    r_delay = 5;
    exp_mw.push_back(mw(32'h0000_0300, 32'hC0C0_0001, 4'hF));
    exp_b.push_back(bx(0, 2'b00));
    exp_mar.push_back(32'h0000_2040);
    re.slv = 8'd1; re.data = 32'hDEAD_2040; re.resp = 2'b00;
    exp_r.push_back(re);
    fork
      do_write(0, 32'h0000_0300, 32'hC0C0_0001, 4'hF, 0, 0);
      do_read(1, 32'h0000_2040);
    join
    r_delay = 0;
    exp_mar.push_back(32'h0000_1044);
    re.slv = 8'd0; re.data = 32'hDEAD_1044; re.resp = 2'b10;
    exp_r.push_back(re);
    do_read(0, 32'h0000_1044);

    // 5: slave 0 holds BREADY low 4 cycles while slave 1 waits
    exp_mw.push_back(mw(32'h0000_0400, 32'h5555_0000, 4'hF));
    exp_b.push_back(bx(0, 2'b00));
    exp_mw.push_back(mw(32'h0000_1400, 32'h5555_0001, 4'hC));
    exp_b.push_back(bx(1, 2'b10));
    fork
      do_write(0, 32'h0000_0400, 32'h5555_0000, 4'hF, 0, 4);
      begin
        repeat (2) @(posedge ACLK);
        #1;
        do_write(1, 32'h0000_1400, 32'h5555_0001, 4'hC, 0, 0);
      end
    join
    // leaves wr_ptr at 1 so the reset below has something to clear
    exp_mw.push_back(mw(32'h0000_0500, 32'h6666_0000, 4'hF));
    exp_b.push_back(bx(0, 2'b00));
    do_write(0, 32'h0000_0500, 32'h6666_0000, 4'hF, 0, 0);

    // 6: reset while slave 1 sits in RESP
    exp_mw.push_back(mw(32'h0000_0600, 32'h7777_0000, 4'hF));
    send_aw_w(1, 32'h0000_0600, 32'h7777_0000, 4'hF, 0);
    begin
      logic got;
      int cyc;
      got = 1'b0; cyc = 0;
      while (!got && cyc < 200) begin
        @(negedge ACLK);
        got = S_AXI_BVALID[1];
        cyc++;
      end
      chk("t6_bvalid_before_reset", 64'(got), 64'(1));
    end
    @(posedge ACLK); #3;
    ARESETN = 1'b0;
    #1;
    chk("mid_reset_quiet", quiet_vec(), 64'(0));
    S_AXI_AWVALID = 2'b11;
    repeat (2) @(posedge ACLK);
    #3;
    ARESETN = 1'b1;
    #1;
    chk("post_reset2_quiet", quiet_vec(), 64'(0));
    exp_mw.push_back(mw(32'h0000_0700, 32'h8888_0000, 4'hF));
    exp_b.push_back(bx(0, 2'b00));
    exp_mw.push_back(mw(32'h0000_1700, 32'h8888_0001, 4'hF));
    exp_b.push_back(bx(1, 2'b10));
    fork
      do_write(0, 32'h0000_0700, 32'h8888_0000, 4'hF, 0, 0);
      do_write(1, 32'h0000_1700, 32'h8888_0001, 4'hF, 0, 0);
    join

    repeat (4) @(posedge ACLK);
    #1;
    chk("exp_mw_drained", 64'(exp_mw.size()), 64'(0));
    chk("exp_b_drained", 64'(exp_b.size()), 64'(0));
    chk("exp_r_drained", 64'(exp_r.size()), 64'(0));
    chk("exp_mar_drained", 64'(exp_mar.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: bench did not reach its end");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
